// File: rtl/dlsc_dma_pkg.sv
// Shared definitions for the DMA command/response responder.
//   RESP_*        : response codes returned on axi_r_resp
//   PAGE_BYTES    : burst page size; bursts may not cross a page
//   PAGE_BITS     : log2(PAGE_BYTES)
//   beat_state_t  : beat-engine state encoding
package dlsc_dma_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_BITS  = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BURST
    } beat_state_t;

endpackage

// File: rtl/dlsc_dma_rwresponder_cmdq.sv
// Command queue for the responder: FIFO of {resp, len} with registered flags.
//   push/push_data : write one entry (caller guarantees !full)
//   pop            : advance the read pointer (caller guarantees !empty)
//   retire         : free the slot of the burst that just completed
//   head           : entry at the read pointer (combinational read)
//   full/empty     : registered flags
//   used           : entries pushed and not yet retired
// An entry stays counted against capacity from push until its burst's last
// beat is accepted, so the burst being played out by the beat engine still
// occupies a slot. This keeps "used" equal to the outstanding command count.
module dlsc_dma_rwresponder_cmdq #(
    parameter  int WIDTH = 6,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             retire,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      used
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      used_reg;
    logic [AW:0]      used_next;
    logic [AW:0]      unread_reg;
    logic [AW:0]      unread_next;
    logic             full_reg;
    logic             empty_reg;

    always_comb begin
        used_next   = used_reg + (AW+1)'(push) - (AW+1)'(retire);
        unread_next = unread_reg + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            used_reg   <= '0;
            unread_reg <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            used_reg   <= used_next;
            unread_reg <= unread_next;
            full_reg   <= (used_next == (AW+1)'(DEPTH));
            empty_reg  <= (unread_next == '0);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
    assign used  = used_reg;

endmodule

// File: rtl/dlsc_dma_rwresponder.sv
// Responder end of the DMA command/response interface.
//   axi_c_*     : burst command channel (addr, len = beats-1)
//   axi_r_*     : response beat channel (valid/ready, last, resp)
//   beat_en     : throttle; low holds off launching a new beat
//   inj_push    : arm injection of inj_resp for the next accepted command
//   busy        : any command outstanding
//   outstanding : commands accepted and not yet completed (0..MOT)
// The response code is decided at command accept and queued with the length;
// the beat engine replays len+1 beats per command in order.
module dlsc_dma_rwresponder
    import dlsc_dma_pkg::*;
#(
    parameter int              ADDR     = 32,
    parameter int              LEN      = 4,
    parameter int              LSB      = 2,
    parameter int              MOT      = 16,
    parameter logic [ADDR-1:0] WIN_BASE = '0,
    parameter logic [ADDR-1:0] WIN_MASK = 32'h0000_FFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               axi_c_ready,
    input  logic               axi_c_valid,
    input  logic [ADDR-1:0]    axi_c_addr,
    input  logic [LEN-1:0]     axi_c_len,
    input  logic               axi_r_ready,
    output logic               axi_r_valid,
    output logic               axi_r_last,
    output logic [1:0]         axi_r_resp,
    input  logic               beat_en,
    input  logic               inj_push,
    input  logic [1:0]         inj_resp,
    output logic               busy,
    output logic [$clog2(MOT):0] outstanding
);

    // Beat-index width within a page, and a sum width one bit wider than
    // either operand so the page-cross check cannot wrap.
    localparam int PB = PAGE_BITS - LSB;
    localparam int SW = ((PB > LEN) ? PB : LEN) + 1;
    localparam int QW = 2 + LEN;

    logic          accept;
    logic [1:0]    c_resp;
    logic [SW-1:0] page_end;
    logic          page_cross;
    logic          inj_armed_reg;
    logic [1:0]    inj_resp_reg;

    logic          q_pop;
    logic          q_retire;
    logic [QW-1:0] q_head;
    logic          q_full;
    logic          q_empty;
    logic [LEN-1:0] head_len;
    logic [1:0]    head_resp;

    beat_state_t   state_reg, state_next;
    logic [LEN-1:0] cnt_reg, cnt_next;
    logic [1:0]    resp_reg, resp_next;
    logic          valid_reg, valid_next;
    logic          hs;
    logic          last_beat;

    assign axi_c_ready = !q_full;
    assign accept      = axi_c_valid && axi_c_ready;

    // Address decode at accept time.
    assign page_end   = SW'(axi_c_addr[PAGE_BITS-1:LSB]) + SW'(axi_c_len);
    assign page_cross = page_end > SW'((1 << PB) - 1);

    always_comb begin
        c_resp = RESP_OKAY;
        if ((axi_c_addr & ~WIN_MASK) != WIN_BASE) begin
            c_resp = RESP_DECERR;
        end else if (page_cross) begin
            c_resp = RESP_SLVERR;
        end else if (inj_armed_reg) begin
            c_resp = inj_resp_reg;
        end
    end

    // A push coinciding with an accept re-arms for the following command,
    // so it takes priority over the disarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_armed_reg <= 1'b0;
            inj_resp_reg  <= RESP_OKAY;
        end else if (inj_push) begin
            inj_armed_reg <= 1'b1;
            inj_resp_reg  <= inj_resp;
        end else if (accept) begin
            inj_armed_reg <= 1'b0;
        end
    end

    dlsc_dma_rwresponder_cmdq #(
        .WIDTH (QW),
        .DEPTH (MOT)
    ) u_cmdq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data ({c_resp, axi_c_len}),
        .pop       (q_pop),
        .retire    (q_retire),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .used      (outstanding)
    );

    assign head_resp = q_head[QW-1:LEN];
    assign head_len  = q_head[LEN-1:0];

    // Beat engine. cnt holds the beats remaining after the current one.
    assign hs        = valid_reg && axi_r_ready;
    assign last_beat = (cnt_reg == '0);
    assign q_retire  = hs && last_beat;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        resp_next  = resp_reg;
        valid_next = valid_reg;
        q_pop      = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (!q_empty) begin
                    q_pop      = 1'b1;
                    cnt_next   = head_len;
                    resp_next  = head_resp;
                    valid_next = beat_en;
                    state_next = beat_en ? ST_BURST : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_en) begin
                    valid_next = 1'b1;
                    state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (hs) begin
                    if (last_beat) begin
                        // Back-to-back reload keeps bursts gap-free.
                        if (!q_empty) begin
                            q_pop      = 1'b1;
                            cnt_next   = head_len;
                            resp_next  = head_resp;
                            valid_next = beat_en;
                            state_next = beat_en ? ST_BURST : ST_LOAD;
                        end else begin
                            valid_next = 1'b0;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cnt_next   = cnt_reg - LEN'(1);
                        valid_next = beat_en;
                    end
                end else if (!valid_reg && beat_en) begin
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            resp_reg  <= RESP_OKAY;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            resp_reg  <= resp_next;
            valid_reg <= valid_next;
        end
    end

    assign axi_r_valid = valid_reg;
    assign axi_r_last  = valid_reg && last_beat;
    assign axi_r_resp  = resp_reg;
    assign busy        = (outstanding != '0);

endmodule
